// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and signed operand/product/accumulator types for the
// FIR multiply-accumulate datapath.
//   DATA_W : sample / coefficient width (two's complement)
//   PROD_W : full-precision product width (2*DATA_W)
//   ACC_W  : accumulator width (PROD_W + 7 guard bits, 128 full-scale products)
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 39;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/mult16x16_s.sv
// mult16x16_s: purely combinational signed 16x16 -> 32 multiplier.
// Radix-4 Booth recoding of the multiplier b into 8 partial products, summed
// with a three-level adder tree.
// Ports:
//   a : input  data_t  signed multiplicand
//   b : input  data_t  signed multiplier (Booth-recoded)
//   p : output prod_t  full-precision signed product, never truncated
module mult16x16_s
  import alu_pkg::*;
(
  input  data_t a,
  input  data_t b,
  output prod_t p
);

  localparam int NPP = DATA_W / 2;

  prod_t pp [NPP];
  prod_t l1 [NPP/2];
  prod_t l2 [NPP/4];

  // Booth digit selection: each 3-bit window of {b,0} picks 0, +-a or +-2a.
  always_comb begin
    logic [DATA_W:0] bx;
    logic [2:0]      sel;
    prod_t           ax;
    prod_t           mult;
    bx   = {b, 1'b0};
    ax   = {{DATA_W{a[DATA_W-1]}}, a};
    sel  = 3'b000;
    mult = 32'sd0;
    pp   = '{default: 32'sd0};
    for (int i = 0; i < NPP; i++) begin
      sel = bx[2*i +: 3];
      case (sel)
        3'b001, 3'b010: mult = ax;
        3'b011:         mult = ax <<< 1;
        3'b100:         mult = -(ax <<< 1);
        3'b101, 3'b110: mult = -ax;
        default:        mult = 32'sd0;
      endcase
      // Weight 4^i; bits shifted out are redundant sign copies since the
      // final sum always fits in 32 signed bits.
      pp[i] = mult <<< (2*i);
    end
  end

  // Adder tree: 8 -> 4 -> 2 -> 1, all modulo 2^32.
  always_comb begin
    l1 = '{default: 32'sd0};
    l2 = '{default: 32'sd0};
    for (int j = 0; j < NPP/2; j++) begin
      l1[j] = pp[2*j] + pp[2*j+1];
    end
    for (int k = 0; k < NPP/4; k++) begin
      l2[k] = l1[2*k] + l1[2*k+1];
    end
    p = l2[0] + l2[1];
  end

endmodule

// File: rtl/alu.sv
// alu: signed multiply-accumulate datapath for the FIR filter.
// Every clock the product X*B is registered into prod while the previous
// prod is sign-extended and added into the wrapping accumulator acc.
// An operand pair therefore reaches y two clocks after it is sampled.
// Ports:
//   clk   : input  clock, all state on rising edge
//   reset : input  synchronous active-high clear of prod and acc
//   X     : input  [DATA_W-1:0] signed sample
//   B     : input  [DATA_W-1:0] signed coefficient
//   y     : output [ACC_W-1:0]  signed accumulator, straight from acc
module alu #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int ACC_W  = alu_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] X,
  input  logic signed [DATA_W-1:0] B,
  output logic signed [ACC_W-1:0]  y
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_next;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;

  mult16x16_s u_mult (
    .a (X),
    .b (B),
    .p (prod_next)
  );

  // Accumulator adder: uses the registered (previous) product, wraps modulo 2^ACC_W.
  always_comb begin
    acc_next = {ACC_W{1'b0}};
    acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Pipeline registers; reset wins over accumulation and drops the product
  // sampled on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= {PROD_W{1'b0}};
      acc  <= {ACC_W{1'b0}};
    end else begin
      prod <= prod_next;
      acc  <= acc_next;
    end
  end

  assign y = acc;

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed scenarios plus a randomized
// regression compared against a list-of-products reference model.
module tb_alu;
  import alu_pkg::*;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] B;
  logic [ACC_W-1:0]  y;

  int n_checks;
  int n_fail;

  // Reference model: every product sampled since the last reset, in order.
  // y after an edge is the wrapped sum of all of them except the newest.
  longint prods[$];

  alu dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .B     (B),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input logic r, input int xv, input int bv);
    reset = r;
    X = xv[DATA_W-1:0];
    B = bv[DATA_W-1:0];
    @(posedge clk);
    #1;
    if (r) prods.delete();
    else   prods.push_back(longint'(xv) * longint'(bv));
  endtask

  function automatic logic [ACC_W-1:0] model_y();
    longint s;
    s = 64'sd0;
    for (int i = 0; i + 1 < prods.size(); i++) s += prods[i];
    return s[ACC_W-1:0];
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1234, -5);
      n_checks++;
      if (y !== {ACC_W{1'b0}}) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: y=%0d expected 0", i, $signed(y));
      end
    end
  endtask

  task automatic test_constant();
    longint e;
    logic [ACC_W-1:0] ev;
    cycle(1'b1, 2, 1);
    for (int n = 1; n <= 1000; n++) begin
      cycle(1'b0, 2, 1);
      e = 2 * (n - 1);
      ev = e[ACC_W-1:0];
      n_checks++;
      if (y !== ev) begin
        n_fail++;
        $display("FAIL constant_acc edge %0d: y=%0d expected %0d", n, $signed(y), e);
      end
    end
  endtask

  task automatic test_corners();
    longint e;
    logic [ACC_W-1:0] ev;
    cycle(1'b1, 0, 0);
    cycle(1'b0, -32768, -32768);
    cycle(1'b0, 0, 0);
    e = 64'sd1073741824;
    ev = e[ACC_W-1:0];
    n_checks++;
    if (y !== ev) begin
      n_fail++;
      $display("FAIL corner_negneg: y=%0d expected %0d", $signed(y), e);
    end
    cycle(1'b0, 0, 0);
    n_checks++;
    if (y !== ev) begin
      n_fail++;
      $display("FAIL corner_negneg_hold: y=%0d expected %0d", $signed(y), e);
    end
    cycle(1'b1, 0, 0);
    cycle(1'b0, -32768, 32767);
    cycle(1'b0, 0, 0);
    e = -64'sd1073709056;
    ev = e[ACC_W-1:0];
    n_checks++;
    if (y !== ev) begin
      n_fail++;
      $display("FAIL corner_negpos: y=%0d expected %0d", $signed(y), e);
    end
  endtask

  task automatic test_midstream_reset();
    logic [ACC_W-1:0] ev;
    cycle(1'b1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 3, 7);
    ev = 39'd189;
    n_checks++;
    if (y !== ev) begin
      n_fail++;
      $display("FAIL mid_accum: y=%0d expected 189", $signed(y));
    end
    // Operands present on the reset edge must be discarded.
    cycle(1'b1, 3, 7);
    n_checks++;
    if (y !== {ACC_W{1'b0}}) begin
      n_fail++;
      $display("FAIL mid_reset: y=%0d expected 0", $signed(y));
    end
    cycle(1'b0, 5, 5);
    n_checks++;
    if (y !== {ACC_W{1'b0}}) begin
      n_fail++;
      $display("FAIL mid_restart1: y=%0d expected 0", $signed(y));
    end
    cycle(1'b0, 5, 5);
    ev = 39'd25;
    n_checks++;
    if (y !== ev) begin
      n_fail++;
      $display("FAIL mid_restart2: y=%0d expected 25", $signed(y));
    end
    cycle(1'b0, 0, 0);
    ev = 39'd50;
    n_checks++;
    if (y !== ev) begin
      n_fail++;
      $display("FAIL mid_restart3: y=%0d expected 50", $signed(y));
    end
  endtask

  task automatic test_wrap();
    longint e;
    logic [ACC_W-1:0] ev;
    cycle(1'b1, 0, 0);
    // 256 products land by edge 257; the 257th product lands on edge 258.
    for (int i = 0; i < 257; i++) cycle(1'b0, -32768, -32768);
    e = -(64'sd1 <<< 38);
    ev = e[ACC_W-1:0];
    n_checks++;
    if (y !== ev) begin
      n_fail++;
      $display("FAIL wrap_256: y=%0d expected %0d", $signed(y), e);
    end
    cycle(1'b0, 0, 0);
    e = -(64'sd1 <<< 38) + (64'sd1 <<< 30);
    ev = e[ACC_W-1:0];
    n_checks++;
    if (y !== ev) begin
      n_fail++;
      $display("FAIL wrap_257: y=%0d expected %0d", $signed(y), e);
    end
  endtask

  task automatic test_random();
    int xv;
    int bv;
    logic r;
    logic [ACC_W-1:0] ev;
    cycle(1'b1, 0, 0);
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      xv = int'($urandom_range(0, 65535)) - 32768;
      bv = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 15) == 0) xv = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
      if ($urandom_range(0, 15) == 0) bv = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
      cycle(r, xv, bv);
      ev = model_y();
      n_checks++;
      if (y !== ev) begin
        n_fail++;
        $display("FAIL random cycle %0d: y=%0d expected %0d", i, $signed(y), $signed(ev));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    X        = '0;
    B        = '0;
    test_reset();
    test_constant();
    test_corners();
    test_midstream_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Signed multiply-accumulate datapath for the FIR filter.
- Each clock it multiplies sample `X` by coefficient `B` and adds the product into a running accumulator.
- The accumulator is exposed continuously as `y`.
- The block sits between the tap/coefficient sequencer, which drives `X`/`B` every cycle, and the filter output stage, which reads `y`.

## Interface
Parameters:
- `DATA_W`, default 16: width of `X` and `B`, two's complement.
- `ACC_W`, default 39: accumulator/output width. It equals 2·`DATA_W` + 7 guard bits, giving headroom for 128 full-scale products.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Reset is synchronous and active-high, sampled on the rising edge of `clk`.
- `X`: input, `DATA_W` bits. Signed sample operand.
- `B`: input, `DATA_W` bits. Signed coefficient operand.
- `y`: output, `ACC_W` bits. Signed accumulator value, driven directly from a register.

## Operation
- Two internal registers:
  - `prod` (2·`DATA_W` bits, signed) holds the last product.
  - `acc` (`ACC_W` bits, signed) holds the running sum.
- Rising edge with `reset`=1: `prod` ← 0, `acc` ← 0. Reset overrides all other activity, including in the middle of an accumulation.
- Rising edge with `reset`=0, both registers update in parallel:
  - `prod` ← signed(`X`) × signed(`B`), full-precision 32-bit result.
  - `acc` ← `acc` + sign-extend(`prod`) to `ACC_W`. This uses the old `prod`.
- `y` = `acc` at all times. There is no combinational path from `X`/`B` to `y`.
- Arithmetic rules:
  - Full two's complement.
  - Product never truncates: −32768 × −32768 = +2^30 fits in 32 signed bits.
  - Accumulator wraps modulo 2^`ACC_W`, with no saturation and no overflow flag.
- Accumulation runs every cycle. Clearing between output samples is done by the sequencer asserting `reset` for one cycle.

## Timing
- Reset values: `y` = 0, `prod` = 0.
- Latency: an operand pair presented before edge k appears in `y` after edge k+1, i.e. two clocks.
- Throughput: one multiply-accumulate per clock.
- Reset release: `X`/`B` sampled on the first edge with `reset`=0 contribute to `y` after the second such edge.
- Reset asserted mid-stream:
  - `y` reads 0 after that edge.
  - The product of the `X`/`B` sampled on that edge is discarded.
- `X`/`B` must be stable by the rising edge; no handshake.

## Structure
- Package `alu_pkg` holds:
  - Constants `DATA_W`=16, `PROD_W`=32, `ACC_W`=39.
  - Typedefs `data_t`, `prod_t`, `acc_t` (signed).
- One sub-module, `mult16x16_s`: purely combinational signed 16×16→32 multiplier (radix-4 Booth with adder tree).
  - `alu` registers its output into `prod`.
  - `alu` contains the accumulator adder.

## Test plan
- Reset check: hold `reset`=1 for 2 cycles with `X`=1234, `B`=−5 → `y`=0 throughout.
- Constant accumulation: release reset with `X`=2, `B`=1 held → `y` = 0, 0, 2, 4, 6, … after successive edges; `y`=1998 after edge 1000.
- Signed corners:
  - `X`=−32768, `B`=−32768 for one cycle, then 0 → `y`=1073741824.
  - `X`=−32768, `B`=32767 for one cycle → `y`=−1073709056.
- Mid-stream reset: accumulate `X`=3, `B`=7 for 10 edges (`y`=189), then pulse `reset` for one cycle → `y`=0. Operands applied afterwards restart from 0 with 2-cycle latency.
- Wrap-around: feed 256 consecutive full-scale products (+2^30) → `y` wraps to −2^38 exactly (2^38 modulo 2^39, signed). One more product → `y` = −2^38 + 2^30.
- Random regression: 10,000 random signed `X`/`B` pairs, periodic random resets. Compare `y` each cycle against a 39-bit wrapping reference model with 2-cycle latency.
